// File: rtl/rename_stage_if.sv
// Bundle of the rename stage's upstream group, dispatch handshake and commit free ports.
// The master side drives instructions, dispatch readiness and frees; the slave side is the rename stage.
interface rename_stage_if #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);

  logic [1:0]           i_valid;
  logic [1:0][AW-1:0]   i_rs1;
  logic [1:0][AW-1:0]   i_rs2;
  logic [1:0][AW-1:0]   i_rd;
  logic [1:0]           i_rd_we;
  logic                 o_ready;
  logic [1:0]           o_valid;
  logic                 i_ready;
  logic [1:0][PW-1:0]   o_prs1;
  logic [1:0][PW-1:0]   o_prs2;
  logic [1:0][PW-1:0]   o_prd;
  logic [1:0][PW-1:0]   o_old_prd;
  logic [1:0]           o_prd_we;
  logic [1:0]           i_free_en;
  logic [1:0][PW-1:0]   i_free_preg;
  logic [PW:0]          o_free_count;

  modport master (
    output i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_ready, i_free_en, i_free_preg,
    input  o_ready, o_valid, o_prs1, o_prs2, o_prd, o_old_prd, o_prd_we, o_free_count
  );

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_ready, i_free_en, i_free_preg,
    output o_ready, o_valid, o_prs1, o_prs2, o_prd, o_old_prd, o_prd_we, o_free_count
  );
endinterface

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup with intra-group bypass, free-list allocation,
// commit-side frees, and a one-deep output register toward dispatch.
module rename_stage #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  rename_stage_if.slave bus
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);

  logic [PW-1:0]      rat_q [NUM_AREGS];
  logic [PW-1:0]      fl_q  [NUM_PREGS];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, tail1;
  logic [PW:0]        count_q, count_d;

  logic [1:0]         valid_q, valid_d, we_q, we_d;
  logic [1:0][PW-1:0] prs1_q, prs1_d, prs2_q, prs2_d, prd_q, prd_d, old_q, old_d;

  logic [1:0]         alloc;
  logic [1:0][PW-1:0] new_preg;
  logic [1:0]         grp_we;
  logic [1:0][PW-1:0] grp_prs1, grp_prs2, grp_prd, grp_old;
  logic               ready, accept;
  logic [1:0]         n_alloc;
  logic [1:0]         push, drop;
  logic [PW+1:0]      occ;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
    return PW'((int'(p) + n) % NUM_PREGS);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_alloc
    assign alloc[gi] = bus.i_valid[gi] & bus.i_rd_we[gi] & (bus.i_rd[gi] != '0);
  end

  // Slot 1 takes the head when slot 0 does not allocate.
  assign new_preg[0] = fl_q[head_q];
  assign new_preg[1] = alloc[0] ? fl_q[wrap_add(head_q, 1)] : fl_q[head_q];

  assign ready   = (~|valid_q | bus.i_ready) & (count_q >= (PW+1)'(2));
  assign accept  = ready & |bus.i_valid;
  assign n_alloc = accept ? ({1'b0, alloc[0]} + {1'b0, alloc[1]}) : 2'd0;

  always_comb begin
    grp_prs1 = '0;
    grp_prs2 = '0;
    grp_prd  = '0;
    grp_old  = '0;
    grp_we   = '0;
    for (int s = 0; s < 2; s++) begin
      if (bus.i_valid[s]) begin
        grp_prs1[s] = (bus.i_rs1[s] == '0) ? '0 : rat_q[bus.i_rs1[s]];
        grp_prs2[s] = (bus.i_rs2[s] == '0) ? '0 : rat_q[bus.i_rs2[s]];
        if (alloc[s]) begin
          grp_we[s]  = 1'b1;
          grp_prd[s] = new_preg[s];
          grp_old[s] = rat_q[bus.i_rd[s]];
        end
      end
    end
    // Slot 1 must observe slot 0's write as if the two renamed in sequence.
    if (alloc[0] && bus.i_valid[1]) begin
      if (bus.i_rs1[1] == bus.i_rd[0]) grp_prs1[1] = new_preg[0];
      if (bus.i_rs2[1] == bus.i_rd[0]) grp_prs2[1] = new_preg[0];
      if (alloc[1] && (bus.i_rd[1] == bus.i_rd[0])) grp_old[1] = new_preg[0];
    end
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    prd_d   = prd_q;
    old_d   = old_q;
    if (accept) begin
      valid_d = bus.i_valid;
      we_d    = grp_we;
      prs1_d  = grp_prs1;
      prs2_d  = grp_prs2;
      prd_d   = grp_prd;
      old_d   = grp_old;
    end else if (bus.i_ready || (valid_q == 2'b00)) begin
      valid_d = '0;
      we_d    = '0;
      prs1_d  = '0;
      prs2_d  = '0;
      prd_d   = '0;
      old_d   = '0;
    end
  end

  // Pops are counted before pushes so a same-cycle free never sees a stale full list.
  always_comb begin
    push = '0;
    drop = '0;
    occ  = (PW+2)'(count_q) - (PW+2)'(n_alloc);
    for (int p = 0; p < 2; p++) begin
      if (bus.i_free_en[p] && (bus.i_free_preg[p] != '0)) begin
        if (occ < (PW+2)'(NUM_PREGS)) begin
          push[p] = 1'b1;
          occ     = occ + (PW+2)'(1);
        end else begin
          drop[p] = 1'b1;
        end
      end
    end
    count_d = occ[PW:0];
    head_d  = wrap_add(head_q, int'(n_alloc));
    tail1   = push[0] ? wrap_add(tail_q, 1) : tail_q;
    tail_d  = wrap_add(tail_q, int'(push[0]) + int'(push[1]));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int a = 0; a < NUM_AREGS; a++) rat_q[a] <= PW'(a);
      for (int i = 0; i < NUM_PREGS; i++)
        fl_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(i + NUM_AREGS) : '0;
      head_q  <= '0;
      tail_q  <= PW'(NUM_PREGS - NUM_AREGS);
      count_q <= (PW+1)'(NUM_PREGS - NUM_AREGS);
      valid_q <= '0;
      we_q    <= '0;
      prs1_q  <= '0;
      prs2_q  <= '0;
      prd_q   <= '0;
      old_q   <= '0;
    end else begin
      if (accept && alloc[0]) rat_q[bus.i_rd[0]] <= new_preg[0];
      if (accept && alloc[1]) rat_q[bus.i_rd[1]] <= new_preg[1];
      if (push[0]) fl_q[tail_q] <= bus.i_free_preg[0];
      if (push[1]) fl_q[tail1]  <= bus.i_free_preg[1];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      prs1_q  <= prs1_d;
      prs2_q  <= prs2_d;
      prd_q   <= prd_d;
      old_q   <= old_d;
    end
  end

  a_no_free_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) drop == 2'b00);

  assign bus.o_ready      = ready;
  assign bus.o_valid      = valid_q;
  assign bus.o_prd_we     = we_q;
  assign bus.o_prs1       = prs1_q;
  assign bus.o_prs2       = prs2_q;
  assign bus.o_prd        = prd_q;
  assign bus.o_old_prd    = old_q;
  assign bus.o_free_count = count_q;
endmodule

// File: tb/tb_rename_stage.sv
// Rename stage bench: directed scenarios with literal expectations, then random traffic
// checked every cycle against a sequential rename model (RAT array + free-list queue).
module tb_rename_stage;
  localparam int NA = 32;
  localparam int NP = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_stage_if #(.NUM_AREGS(NA), .NUM_PREGS(NP)) bus();
  rename_stage #(.NUM_AREGS(NA), .NUM_PREGS(NP)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int rat[NA];
  int fq[$];
  int retq[$];
  logic [1:0] e_valid, e_we;
  int e_prs1[2], e_prs2[2], e_prd[2], e_old[2];
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    e_valid = '0;
    e_we = '0;
    for (int s = 0; s < 2; s++) begin
      e_prs1[s] = 0; e_prs2[s] = 0; e_prd[s] = 0; e_old[s] = 0;
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) rat[a] = a;
    fq.delete();
    for (int p = NA; p < NP; p++) fq.push_back(p);
    retq.delete();
    model_clear();
  endtask

  function automatic bit exp_ready();
    return (e_valid == 2'b00 || bus.i_ready) && fq.size() >= 2;
  endfunction

  // Renames the group slot by slot, so slot 1 naturally sees slot 0's mapping.
  task automatic model_clock();
    int rd;
    if (exp_ready() && bus.i_valid != 2'b00) begin
      model_clear();
      for (int s = 0; s < 2; s++) begin
        e_valid[s] = bus.i_valid[s];
        if (bus.i_valid[s]) begin
          e_prs1[s] = (bus.i_rs1[s] == 0) ? 0 : rat[int'(bus.i_rs1[s])];
          e_prs2[s] = (bus.i_rs2[s] == 0) ? 0 : rat[int'(bus.i_rs2[s])];
          rd = int'(bus.i_rd[s]);
          if (bus.i_rd_we[s] && rd != 0) begin
            e_we[s]  = 1'b1;
            e_old[s] = rat[rd];
            e_prd[s] = fq.pop_front();
            rat[rd]  = e_prd[s];
            retq.push_back(e_old[s]);
          end
        end
      end
    end else if (bus.i_ready || e_valid == 2'b00) begin
      model_clear();
    end
    for (int p = 0; p < 2; p++)
      if (bus.i_free_en[p] && bus.i_free_preg[p] != 0) fq.push_back(int'(bus.i_free_preg[p]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid", 32'(bus.o_valid), 32'(e_valid));
      chk("o_free_count", 32'(bus.o_free_count), fq.size());
      chk("o_ready", 32'(bus.o_ready), 32'(exp_ready()));
      chk("o_prd_we", 32'(bus.o_prd_we), 32'(e_we));
      for (int s = 0; s < 2; s++) begin
        if (e_valid[s]) begin
          chk($sformatf("o_prs1[%0d]", s), 32'(bus.o_prs1[s]), e_prs1[s]);
          chk($sformatf("o_prs2[%0d]", s), 32'(bus.o_prs2[s]), e_prs2[s]);
          chk($sformatf("o_prd[%0d]", s), 32'(bus.o_prd[s]), e_prd[s]);
          chk($sformatf("o_old_prd[%0d]", s), 32'(bus.o_old_prd[s]), e_old[s]);
        end
      end
    end
  end

  task automatic idle();
    bus.i_valid = '0; bus.i_rd_we = '0;
    bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd = '0;
    bus.i_free_en = '0; bus.i_free_preg = '0;
    bus.i_ready = 1'b1;
  endtask

  task automatic set_slot(input int s, input bit v, input bit we, input int rd, input int rs1, input int rs2);
    bus.i_valid[s] = v;
    bus.i_rd_we[s] = we;
    bus.i_rd[s]    = 5'(rd);
    bus.i_rs1[s]   = 5'(rs1);
    bus.i_rs2[s]   = 5'(rs2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int idx;
    idle();
    model_reset();

    // Reset state and first two-slot group with bypass on slot 1 rs1.
    do_reset();
    chk("rst o_valid", 32'(bus.o_valid), 0);
    chk("rst o_free_count", 32'(bus.o_free_count), 32);
    chk("rst o_prd", 32'(bus.o_prd), 0);
    set_slot(0, 1, 1, 5, 1, 0);
    set_slot(1, 1, 1, 6, 5, 0);
    tick();
    idle();
    chk("t1 prd0", 32'(bus.o_prd[0]), 32);
    chk("t1 prd1", 32'(bus.o_prd[1]), 33);
    chk("t1 prs1_0", 32'(bus.o_prs1[0]), 1);
    chk("t1 prs1_1", 32'(bus.o_prs1[1]), 32);
    chk("t1 old0", 32'(bus.o_old_prd[0]), 5);
    chk("t1 old1", 32'(bus.o_old_prd[1]), 6);
    chk("t1 count", 32'(bus.o_free_count), 30);
    tick();

    // rd=0 in slot 0 does not allocate; slot 1 takes the head.
    do_reset();
    set_slot(0, 1, 1, 0, 2, 3);
    set_slot(1, 1, 1, 7, 0, 0);
    tick();
    idle();
    chk("t2 prd_we", 32'(bus.o_prd_we), 2);
    chk("t2 prd1", 32'(bus.o_prd[1]), 32);
    chk("t2 prd0", 32'(bus.o_prd[0]), 0);
    chk("t2 old0", 32'(bus.o_old_prd[0]), 0);
    chk("t2 count", 32'(bus.o_free_count), 31);
    tick();

    // Both slots write rd=3.
    do_reset();
    set_slot(0, 1, 1, 3, 0, 0);
    set_slot(1, 1, 1, 3, 0, 0);
    tick();
    idle();
    chk("t3 prd0", 32'(bus.o_prd[0]), 32);
    chk("t3 prd1", 32'(bus.o_prd[1]), 33);
    chk("t3 old0", 32'(bus.o_old_prd[0]), 3);
    chk("t3 old1", 32'(bus.o_old_prd[1]), 32);
    set_slot(0, 1, 0, 0, 3, 0);
    tick();
    idle();
    chk("t3 rs1=3 map", 32'(bus.o_prs1[0]), 33);
    tick();

    // Stall with a pending group, drain, then reset in the middle of a stall.
    do_reset();
    set_slot(0, 1, 1, 5, 0, 0);
    bus.i_ready = 1'b0;
    tick();
    set_slot(0, 1, 1, 6, 5, 0);
    #1;
    chk("t4 ready stalled", 32'(bus.o_ready), 0);
    tick();
    tick();
    chk("t4 hold prd0", 32'(bus.o_prd[0]), 32);
    chk("t4 hold valid", 32'(bus.o_valid), 1);
    chk("t4 hold count", 32'(bus.o_free_count), 31);
    bus.i_ready = 1'b1;
    tick();
    chk("t4 drain prd0", 32'(bus.o_prd[0]), 33);
    chk("t4 drain prs1_0", 32'(bus.o_prs1[0]), 32);
    idle();
    bus.i_ready = 1'b0;
    tick();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4 async valid", 32'(bus.o_valid), 0);
    chk("t4 async count", 32'(bus.o_free_count), 32);
    do_reset();
    set_slot(0, 1, 0, 0, 5, 6);
    tick();
    idle();
    chk("t4 rat id rs1", 32'(bus.o_prs1[0]), 5);
    chk("t4 rat id rs2", 32'(bus.o_prs2[0]), 6);
    tick();

    // Drain the free list to one entry, free p5/p6, then allocate them back.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      set_slot(0, 1, 1, 2 * k + 1, 0, 0);
      set_slot(1, 1, 1, 2 * k + 2, 0, 0);
      tick();
    end
    idle();
    set_slot(0, 1, 1, 31, 0, 0);
    tick();
    idle();
    tick();
    chk("t5 count low", 32'(bus.o_free_count), 1);
    chk("t5 ready low", 32'(bus.o_ready), 0);
    bus.i_free_en = 2'b11;
    bus.i_free_preg[0] = 6'd5;
    bus.i_free_preg[1] = 6'd6;
    tick();
    idle();
    #1;
    chk("t5 count freed", 32'(bus.o_free_count), 3);
    chk("t5 ready back", 32'(bus.o_ready), 1);
    set_slot(0, 1, 1, 1, 0, 0);
    tick();
    idle();
    chk("t5 alloc 63", 32'(bus.o_prd[0]), 63);
    set_slot(0, 1, 1, 2, 0, 0);
    set_slot(1, 1, 1, 3, 0, 0);
    tick();
    idle();
    chk("t5 alloc 5", 32'(bus.o_prd[0]), 5);
    chk("t5 alloc 6", 32'(bus.o_prd[1]), 6);
    tick();

    // Random traffic; frees come only from retired old mappings, so the list never overflows.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      bus.i_valid = (r < 2) ? 2'b00 : 2'($urandom_range(1, 3));
      for (int s = 0; s < 2; s++) begin
        bus.i_rd_we[s] = ($urandom_range(0, 9) < 8);
        bus.i_rd[s]    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.i_rs1[s]   = 5'($urandom_range(0, 31));
        bus.i_rs2[s]   = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 9) < 3) bus.i_rs1[1] = bus.i_rd[0];
      if ($urandom_range(0, 9) < 2) bus.i_rd[1] = bus.i_rd[0];
      bus.i_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 99);
        if (r < 35 && retq.size() > 0) begin
          idx = $urandom_range(0, retq.size() - 1);
          bus.i_free_en[p] = 1'b1;
          bus.i_free_preg[p] = 6'(retq[idx]);
          retq.delete(idx);
        end else if (r < 38) begin
          bus.i_free_en[p] = 1'b1;
          bus.i_free_preg[p] = 6'd0;
        end else begin
          bus.i_free_en[p] = 1'b0;
          bus.i_free_preg[p] = 6'($urandom_range(0, 63));
        end
      end
      tick();
    end
    idle();
    tick();
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Two-wide register-rename stage directly upstream of dispatch_reg.
- Maps architectural rs1/rs2/rd to physical registers (p_reg) through a register alias table (RAT) and a free-list FIFO.
- Presents renamed operands to dispatch, whose physical addresses feed register_file read ports.
- Commit returns retired old physical registers through two free ports.

Parameters:
NUM_AREGS, 32, architectural registers; index width 5.
NUM_PREGS, 64, physical registers; index width PW = clog2(NUM_PREGS) = 6.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  2  per-slot instruction valid; slot 0 older
i_rs1  in  2x5  architectural source 1 per slot
i_rs2  in  2x5  architectural source 2 per slot
i_rd  in  2x5  architectural destination per slot
i_rd_we  in  2  slot writes rd
o_ready  out  1  stage accepts group this cycle
o_valid  out  2  renamed slot valid to dispatch
i_ready  in  1  dispatch accepts output group
o_prs1  out  2xPW  physical source 1
o_prs2  out  2xPW  physical source 2
o_prd  out  2xPW  newly allocated physical destination
o_old_prd  out  2xPW  previous mapping of rd, freed at commit
o_prd_we  out  2  slot allocated a destination
i_free_en  in  2  commit free requests
i_free_preg  in  2xPW  physical registers to free
o_free_count  out  PW+1  entries in free list

Behaviour:
- Reset (async, i_rst_n=0):
  - RAT[a]=a for all a.
  - Free list holds NUM_AREGS..NUM_PREGS-1 in ascending order; o_free_count=32.
  - o_valid=0; all data outputs 0.
- Handshake:
  - Output register "empty" when o_valid==0.
  - o_ready = (empty | i_ready) & (o_free_count >= 2).
  - Accept when o_ready & |i_valid.
  - Output register loads on accept; clears to o_valid=0 when i_ready & no accept; holds when o_valid!=0 & !i_ready.
  - Latency: accepted group appears on outputs the next cycle.
- Allocation:
  - Slot s allocates when i_valid[s] & i_rd_we[s] & i_rd[s]!=0.
  - Slot 0 pops the free-list head; slot 1 pops the next entry.
  - If only slot 1 allocates, it takes the head.
  - RAT[rd] <= new preg; o_old_prd = RAT[rd] before the group.
  - rd==0 or !rd_we: o_prd_we=0, o_prd=0, o_old_prd=0; RAT untouched.
- Intra-group bypass:
  - Slot 1 rs1/rs2 equal to slot 0 allocated rd use slot 0's new preg.
  - Both slots writing the same rd: RAT ends with slot 1's preg; slot 1 o_old_prd = slot 0's new preg.
- Sources: rs==0 always maps to p0. RAT[0] stays 0.
- Free list:
  - Circular buffer, NUM_PREGS entries; head/tail wrap modulo NUM_PREGS.
  - Push order: free port 0, then port 1. i_free_preg==0 ignored.
  - Frees pushed in cycle N are allocatable from cycle N+1.
  - Simultaneous events: count_next = count - allocs + frees.
  - Push at full count (NUM_PREGS) is a protocol error; simulation assertion fires, push dropped.
- i_valid=2'b10 is legal: slot 1 renamed alone; o_valid=2'b10.
- Reset mid-stall discards the held group and restores the reset state.

Test Plan:
- Reset, then group {slot0: rd=5 rs1=1; slot1: rd=6 rs1=5} -> next cycle o_prd={32,33}, o_prs1={1,32}, o_old_prd={5,6}, o_free_count=30.
- rd=0 with rd_we=1 in slot 0, rd=7 in slot 1 -> o_prd_we=2'b10, slot 1 o_prd=32, count 31.
- Both slots rd=3 -> o_prd={32,33}, o_old_prd={3,32}; a later rs1=3 maps to 33.
- Hold i_ready=0 two cycles with o_valid set -> outputs stable, o_ready=0, RAT and count unchanged; i_ready=1 drains.
- Allocate until count=1 -> o_ready=0; free p5 and p6 the same cycle -> next cycle count=3, o_ready=1, and allocation after wrap returns 5 then 6.
- Assert i_rst_n low mid-stall -> o_valid=0 immediately, count=32, RAT identity.
